int_gen_dev: RTL and testbench

//  Memory-mapped external-interrupt source on the CPU bridge; the device end of the interrupt/ack protocol.

---
 rtl/int_gen_dev_if.sv | 27 ++
 rtl/int_gen_dev.sv | 153 +++++++++++++++
 tb/tb_int_gen_dev.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/int_gen_dev_if.sv
`default_nettype none
// ============================================================================
// Module   : int_gen_dev_if
// Purpose  : Memory-mapped device bus between the CPU bridge and int_gen_dev.
// Revision : 1.0 - initial release
// ============================================================================
interface int_gen_dev_if;
   logic [31:0] dev_addr;
   logic [31:0] dev_wdata;
   logic [3:0]  dev_byteen;
   logic [31:0] dev_rdata;

   modport master (
      output dev_addr,
      output dev_wdata,
      output dev_byteen,
      input  dev_rdata
   );

   modport slave (
      input  dev_addr,
      input  dev_wdata,
      input  dev_byteen,
      output dev_rdata
   );
endinterface
`default_nettype wire

// File: rtl/int_gen_dev.sv
`default_nettype none
// ============================================================================
// Module   : int_gen_dev
// Purpose  : PC-match external interrupt source with ACK handshake and re-arm.
// Revision : 1.0 - initial release
// ============================================================================
module int_gen_dev #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_7f20,
   parameter logic [31:0] RESET_TARGET = 32'h0000_0000,
   parameter logic [31:0] RESET_CTRL   = 32'h0000_0101
) (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic [31:0] macroscopic_pc,
   int_gen_dev_if.slave     bus,
   output logic             interrupt
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_ASSERT  = 3'd2,
      S_HOLDOFF = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] target_q, target_d;
   logic        en_q, en_d;
   logic        rep_q, rep_d;
   logic [7:0]  max_q, max_d;
   logic [15:0] count_q, count_d;
   logic        irq_q;

   logic [29:0] w_off;
   logic        w_hit;
   logic [1:0]  w_idx;
   logic        w_wr;
   logic        w_ack_wr;
   logic        w_tgt_wr;
   logic        w_ctrl_wr;
   logic [31:0] w_pc_word;
   logic        w_match;
   logic [7:0]  w_max_eff;
   logic        w_unused_lsb;

   // Word offset into the window; the byte-lane bits never affect decoding.
   assign w_off        = bus.dev_addr[31:2] - BASE_ADDR[31:2];
   assign w_hit        = (w_off[29:2] == 28'd0);
   assign w_idx        = w_off[1:0];
   assign w_unused_lsb = ^bus.dev_addr[1:0];

   assign w_wr      = w_hit && (|bus.dev_byteen);
   assign w_ack_wr  = w_wr && (w_idx == 2'd0);
   assign w_tgt_wr  = w_wr && (w_idx == 2'd1);
   assign w_ctrl_wr = w_wr && (w_idx == 2'd2);

   assign w_pc_word = macroscopic_pc & 32'hffff_fffc;
   assign w_match   = (w_pc_word == target_q);
   assign w_max_eff = (max_q == 8'd0) ? 8'd1 : max_q;

   always_comb begin
      target_d = target_q;
      for (int i = 0; i < 4; i++) begin
         if (w_tgt_wr && bus.dev_byteen[i]) begin
            target_d[8*i +: 8] = bus.dev_wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      en_d  = en_q;
      rep_d = rep_q;
      max_d = max_q;
      if (w_ctrl_wr && bus.dev_byteen[0]) begin
         en_d  = bus.dev_wdata[0];
         rep_d = bus.dev_wdata[1];
      end
      if (w_ctrl_wr && bus.dev_byteen[1]) begin
         max_d = bus.dev_wdata[15:8];
      end
   end

   // Disable wins over every other transition, including a same-cycle ACK.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (!en_d) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (en_q) state_d = S_ARMED;
            end
            S_ARMED: begin
               if (w_match) state_d = S_ASSERT;
            end
            S_ASSERT: begin
               if (w_ack_wr) begin
                  if (count_q != 16'hffff) count_d = count_q + 16'd1;
                  if (rep_q && (({1'b0, count_q} + 17'd1) < {9'd0, w_max_eff}))
                     state_d = S_HOLDOFF;
                  else
                     state_d = S_DONE;
               end
            end
            S_HOLDOFF: begin
               if (!w_match) state_d = S_ARMED;
            end
            S_DONE: begin
               if (w_ctrl_wr) state_d = S_HOLDOFF;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RESET_CTRL[0] ? S_ARMED : S_IDLE;
         target_q <= RESET_TARGET;
         en_q     <= RESET_CTRL[0];
         rep_q    <= RESET_CTRL[1];
         max_q    <= RESET_CTRL[15:8];
         count_q  <= 16'd0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         en_q     <= en_d;
         rep_q    <= rep_d;
         max_q    <= max_d;
         count_q  <= count_d;
         irq_q    <= (state_d == S_ASSERT);
      end
   end

   assign interrupt = irq_q;

   always_comb begin
      bus.dev_rdata = 32'd0;
      if (w_hit) begin
         case (w_idx)
            2'd0:    bus.dev_rdata = {31'd0, irq_q};
            2'd1:    bus.dev_rdata = target_q;
            2'd2:    bus.dev_rdata = {16'd0, max_q, 6'd0, rep_q, en_q};
            default: bus.dev_rdata = {16'd0, count_q};
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_int_gen_dev.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_gen_dev
// Purpose  : Directed self-checking bench for int_gen_dev.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_gen_dev;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        irq;
   logic [31:0] d;
   int          n_tests = 0;
   int          n_fail  = 0;

   int_gen_dev_if bus ();

   int_gen_dev #(
      .BASE_ADDR    (32'h0000_7f20),
      .RESET_TARGET (32'h0000_0000),
      .RESET_CTRL   (32'h0000_0101)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .macroscopic_pc (pc),
      .bus            (bus.slave),
      .interrupt      (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      bus.dev_addr   = a;
      bus.dev_wdata  = wd;
      bus.dev_byteen = be;
      @(posedge clk);
      #1;
      bus.dev_byteen = 4'h0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] rdv);
      bus.dev_addr   = a;
      bus.dev_byteen = 4'h0;
      #1;
      rdv = bus.dev_rdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset          = 1'b1;
      pc             = 32'h0;
      bus.dev_addr   = 32'h0;
      bus.dev_wdata  = 32'h0;
      bus.dev_byteen = 4'h0;
      tick(2);

      // Reset defaults
      chk("rst_irq", {31'd0, irq}, 32'd0);
      rd(32'h7f2c, d); chk("rst_count", d, 32'd0);
      rd(32'h7f24, d); chk("rst_target", d, 32'h0);
      rd(32'h7f28, d); chk("rst_ctrl", d, 32'h0000_0101);

      // One-shot fire on pc=0, ACK, no re-fire
      reset = 1'b0;
      tick(1);
      chk("t1_fire", {31'd0, irq}, 32'd1);
      rd(32'h7f20, d); chk("t1_ack_read", d, 32'd1);
      wr(32'h7f20, 32'h0, 4'hf);
      chk("t1_acked", {31'd0, irq}, 32'd0);
      rd(32'h7f2c, d); chk("t1_count", d, 32'd1);
      tick(3);
      chk("t1_nofire", {31'd0, irq}, 32'd0);

      // Repeat mode, MAX=3
      pc    = 32'h3000;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t2_rst_irq", {31'd0, irq}, 32'd0);
      wr(32'h7f24, 32'h0000_3010, 4'hf);
      wr(32'h7f28, 32'h0000_0303, 4'hf);
      tick(1);
      chk("t2_armed_idle", {31'd0, irq}, 32'd0);
      pc = 32'h3010;
      tick(1);
      chk("t2_irq1", {31'd0, irq}, 32'd1);
      wr(32'h7f20, 32'h0, 4'hf);
      chk("t2_ack1", {31'd0, irq}, 32'd0);
      rd(32'h7f2c, d); chk("t2_count1", d, 32'd1);
      tick(3);
      chk("t3_holdoff", {31'd0, irq}, 32'd0);
      pc = 32'h3014;
      tick(1);
      pc = 32'h3010;
      tick(1);
      chk("t2_irq2", {31'd0, irq}, 32'd1);
      wr(32'h7f20, 32'h0, 4'hf);
      chk("t2_ack2", {31'd0, irq}, 32'd0);
      pc = 32'h3000;
      tick(1);
      pc = 32'h3010;
      tick(1);
      chk("t2_irq3", {31'd0, irq}, 32'd1);
      wr(32'h7f20, 32'h0, 4'hf);
      rd(32'h7f2c, d); chk("t2_count3", d, 32'd3);
      pc = 32'h3014;
      tick(1);
      pc = 32'h3010;
      tick(2);
      chk("t2_done", {31'd0, irq}, 32'd0);

      // Disable while asserted, then re-enable
      pc = 32'h3000;
      wr(32'h7f28, 32'h0000_0101, 4'hf);
      tick(1);
      pc = 32'h3010;
      tick(1);
      chk("t4_fire", {31'd0, irq}, 32'd1);
      wr(32'h7f28, 32'h0, 4'hf);
      chk("t4_disabled", {31'd0, irq}, 32'd0);
      rd(32'h7f2c, d); chk("t4_count_kept", d, 32'd3);
      tick(2);
      chk("t4_idle", {31'd0, irq}, 32'd0);
      wr(32'h7f28, 32'h0000_0101, 4'hf);
      chk("t4_reen0", {31'd0, irq}, 32'd0);
      tick(1);
      chk("t4_reen1", {31'd0, irq}, 32'd0);
      tick(1);
      chk("t4_refire", {31'd0, irq}, 32'd1);
      wr(32'h7f20, 32'h0, 4'hf);
      rd(32'h7f2c, d); chk("t4_count4", d, 32'd4);

      // Byte-lane writes, read decode
      wr(32'h7f24, 32'hAABB_CC14, 4'b0001);
      rd(32'h7f24, d); chk("t5_target_lane", d, 32'h0000_3014);
      rd(32'h7f2c, d); chk("t5_count_rd", d, 32'd4);
      rd(32'h7f30, d); chk("t5_outside", d, 32'd0);
      wr(32'h7f2c, 32'h0000_1234, 4'hf);
      rd(32'h7f2f, d); chk("t5_count_ro", d, 32'd4);
      wr(32'h7f28, 32'h0000_0500, 4'b0010);
      rd(32'h7f28, d); chk("t5_ctrl_lane", d, 32'h0000_0501);

      // ACK outside ASSERT, partial-byteen ACK, reset mid-ASSERT
      tick(1);
      wr(32'h7f20, 32'h0, 4'hf);
      rd(32'h7f2c, d); chk("t6_ack_armed", d, 32'd4);
      chk("t6_irq_armed", {31'd0, irq}, 32'd0);
      pc = 32'h3014;
      tick(1);
      chk("t6_fire", {31'd0, irq}, 32'd1);
      wr(32'h7f20, 32'h0, 4'b1000);
      chk("t6_partial_ack", {31'd0, irq}, 32'd0);
      rd(32'h7f2c, d); chk("t6_count5", d, 32'd5);
      wr(32'h7f28, 32'h0000_0101, 4'hf);
      pc = 32'h3000;
      tick(1);
      pc = 32'h3014;
      tick(1);
      chk("t6_fire2", {31'd0, irq}, 32'd1);
      reset = 1'b1;
      tick(1);
      chk("t6_rst_irq", {31'd0, irq}, 32'd0);
      rd(32'h7f2c, d); chk("t6_rst_count", d, 32'd0);
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
